// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce / JK command driver.
// Optional feature macro used by the design: KEY_AUTOREPEAT_EN.
package key_pkg;

   // Per-channel press/release state
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      RELEASING = 2'd3
   } key_state_e;

   // Depth of the raw-input synchroniser
   localparam int unsigned SYNC_STAGES = 2;

   // Counter width large enough for either the debounce or repeat period
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, glitch-filter FSM, saturating
// counter and registered press pulse / debounced level.
// KEY_AUTOREPEAT_EN: when defined, a held key re-emits a pulse every
// REPEAT_CYCLES cycles; when undefined, one pulse per press.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = 16,
   parameter int unsigned REPEAT_CYCLES = 64
) (
   input  logic CK,
   input  logic RESET,
   input  logic KEY,
   output logic PULSE,
   output logic STABLE
);

   localparam int unsigned       CNT_W    = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0]  REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   key_state_e             state;
   key_state_e             state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   pulse_nxt;
   logic                   stable_nxt;

   assign s       = sync[SYNC_STAGES-1];
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // Bring the asynchronous key into the clock domain
   always_ff @(posedge CK) begin
      if (RESET) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], KEY};
      end
   end

   // State, counter and output registers
   always_ff @(posedge CK) begin
      if (RESET) begin
         state  <= IDLE;
         cnt    <= '0;
         PULSE  <= 1'b0;
         STABLE <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         PULSE  <= pulse_nxt;
         STABLE <= stable_nxt;
      end
   end

   // Next-state: advance on a candidate edge, accept after DEB_CYCLES samples
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (s) state_nxt = ARMING;
         ARMING: begin
            if (!s)                    state_nxt = IDLE;
            else if (cnt == DEB_LAST)  state_nxt = HELD;
         end
         HELD:      if (!s) state_nxt = RELEASING;
         RELEASING: begin
            if (s)                     state_nxt = HELD;
            else if (cnt == DEB_LAST)  state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // Outputs: counter update, press pulse and debounced level
   always_comb begin
      cnt_nxt    = cnt;
      pulse_nxt  = 1'b0;
      stable_nxt = STABLE;
      unique case (state)
         IDLE: begin
            if (s) cnt_nxt = CNT_W'(1);
         end
         ARMING: begin
            if (!s) begin
               cnt_nxt = '0;
            end else if (cnt == DEB_LAST) begin
               cnt_nxt    = '0;
               pulse_nxt  = 1'b1;
               stable_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         HELD: begin
            if (!s) begin
               cnt_nxt = CNT_W'(1);
            end else begin
`ifdef KEY_AUTOREPEAT_EN
               if (cnt == REP_LAST) begin
                  cnt_nxt   = '0;
                  pulse_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt_inc;
               end
`else
               cnt_nxt = cnt;
`endif
            end
         end
         RELEASING: begin
            if (s) begin
               cnt_nxt = '0;
            end else if (cnt == DEB_LAST) begin
               cnt_nxt    = '0;
               stable_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            cnt_nxt    = '0;
            stable_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/key_jk_driver.sv
// Two independent debounced key channels producing J/K command pulses
// for the JK flip-flop stage. Simultaneous J and K pulses are passed
// through unarbitrated (toggle command).
// KEY_AUTOREPEAT_EN: enables auto-repeat pulses while a key is held.
module key_jk_driver #(
   parameter int unsigned DEB_CYCLES    = 16,
   parameter int unsigned REPEAT_CYCLES = 64
) (
   input  logic CK,
   input  logic RESET,
   input  logic KEY_J,
   input  logic KEY_K,
   output logic J,
   output logic K,
   output logic STABLE_J,
   output logic STABLE_K
);

   key_debounce_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_ch_j (
      .CK     (CK),
      .RESET  (RESET),
      .KEY    (KEY_J),
      .PULSE  (J),
      .STABLE (STABLE_J)
   );

   key_debounce_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_ch_k (
      .CK     (CK),
      .RESET  (RESET),
      .KEY    (KEY_K),
      .PULSE  (K),
      .STABLE (STABLE_K)
   );

endmodule

// File: tb/tb_key_jk_driver.sv
// Scoreboard bench for key_jk_driver: directed scenarios plus random key
// activity, checked against a run-length reference model.
module tb_key_jk_driver;

   localparam int unsigned DEB = 4;
   localparam int unsigned REP = 8;
`ifdef KEY_AUTOREPEAT_EN
   localparam bit AUTOREP = 1'b1;
`else
   localparam bit AUTOREP = 1'b0;
`endif

   logic CK;
   logic RESET;
   logic KEY_J;
   logic KEY_K;
   logic J;
   logic K;
   logic STABLE_J;
   logic STABLE_K;

   key_jk_driver #(
      .DEB_CYCLES    (DEB),
      .REPEAT_CYCLES (REP)
   ) dut (
      .CK       (CK),
      .RESET    (RESET),
      .KEY_J    (KEY_J),
      .KEY_K    (KEY_K),
      .J        (J),
      .K        (K),
      .STABLE_J (STABLE_J),
      .STABLE_K (STABLE_K)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   typedef struct packed {
      logic j;
      logic k;
      logic sj;
      logic sk;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: raw-sample delay line, run length of samples that
   // disagree with the accepted level, and held-time for auto-repeat.
   logic [1:0] m_p1;
   logic [1:0] m_p2;
   logic [1:0] m_stable;
   logic [1:0] m_pulse;
   int         m_run [2];
   int         m_held[2];

   task automatic model_reset();
      m_p1     = '0;
      m_p2     = '0;
      m_stable = '0;
      m_pulse  = '0;
      for (int c = 0; c < 2; c++) begin
         m_run[c]  = 0;
         m_held[c] = 0;
      end
   endtask

   task automatic model_edge(input logic rj, input logic rk, input logic rst);
      logic [1:0] raw;
      logic       s;
      exp_t       e;
      raw = {rk, rj};
      if (rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < 2; c++) begin
            s          = m_p2[c];
            m_pulse[c] = 1'b0;
            if (s != m_stable[c]) begin
               m_run[c]  = m_run[c] + 1;
               m_held[c] = 0;
               if (m_run[c] == int'(DEB)) begin
                  m_stable[c] = s;
                  m_run[c]    = 0;
                  if (s) m_pulse[c] = 1'b1;
               end
            end else begin
               if (m_stable[c] && AUTOREP) begin
                  if (m_run[c] > 0) begin
                     m_held[c] = 0;
                  end else begin
                     m_held[c] = m_held[c] + 1;
                     if (m_held[c] == int'(REP)) begin
                        m_pulse[c] = 1'b1;
                        m_held[c]  = 0;
                     end
                  end
               end
               m_run[c] = 0;
            end
         end
         m_p2 = m_p1;
         m_p1 = raw;
      end
      e.j  = m_pulse[0];
      e.k  = m_pulse[1];
      e.sj = m_stable[0];
      e.sk = m_stable[1];
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge CK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("J",        J,        e.j);
            check("K",        K,        e.k);
            check("STABLE_J", STABLE_J, e.sj);
            check("STABLE_K", STABLE_K, e.sk);
         end
      end
   end

   task automatic step(input logic kj, input logic kk, input logic rst);
      KEY_J = kj;
      KEY_K = kk;
      RESET = rst;
      @(posedge CK);
      model_edge(kj, kk, rst);
      cyc++;
      @(negedge CK);
   endtask

   task automatic hold(input logic kj, input logic kk, input int n);
      for (int i = 0; i < n; i++) step(kj, kk, 1'b0);
   endtask

   // Stimulus
   initial begin
      logic [8:0] bounce;
      logic       lv_j;
      logic       lv_k;
      int         dur_j;
      int         dur_k;
      logic       rst;

      KEY_J = 1'b0;
      KEY_K = 1'b0;
      RESET = 1'b1;
      model_reset();

      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      hold(1'b0, 1'b0, 3);

      // Clean J press
      hold(1'b1, 1'b0, 20);
      hold(1'b0, 1'b0, 10);

      // Bounced J press: 1,0,1,1,0,1,1,1,1 then held
      bounce = 9'b1_1110_1101;
      for (int i = 0; i < 9; i++) step(bounce[i], 1'b0, 1'b0);
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 10);

      // Simultaneous J and K press
      hold(1'b1, 1'b1, 15);
      hold(1'b0, 1'b1, 2);

      // K release: 4-cycle drop releases, re-press, 2-cycle drop is rejected
      hold(1'b0, 1'b0, 4);
      hold(1'b0, 1'b1, 12);
      hold(1'b0, 1'b0, 2);
      hold(1'b0, 1'b1, 12);
      hold(1'b0, 1'b0, 10);

      // Reset while J is held
      hold(1'b1, 1'b0, 12);
      step(1'b1, 1'b0, 1'b1);
      hold(1'b1, 1'b0, 12);
      hold(1'b0, 1'b0, 10);

      // Long hold for auto-repeat, with a short release bounce
      hold(1'b1, 1'b0, 40);
      hold(1'b0, 1'b0, 2);
      hold(1'b1, 1'b0, 20);
      hold(1'b0, 1'b0, 10);

      // Random key activity with occasional reset
      lv_j  = 1'b0;
      lv_k  = 1'b0;
      dur_j = 0;
      dur_k = 0;
      for (int i = 0; i < 3000; i++) begin
         if (dur_j == 0) begin
            lv_j  = ~lv_j;
            dur_j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                : int'($urandom_range(1, 6));
         end
         if (dur_k == 0) begin
            lv_k  = ~lv_k;
            dur_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                : int'($urandom_range(1, 6));
         end
         rst = ($urandom_range(0, 299) == 0);
         step(lv_j, lv_k, rst);
         dur_j--;
         dur_k--;
      end

      hold(1'b0, 1'b0, 2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
